// File: rtl/fpu_pkg.sv
// fpu_pkg: shared single-precision constants and types for the FPU
// post-processing stages (divide, multiply, sqrt).
//   - field widths, bias, exponent limits, default quiet NaN
//   - rounding-mode encoding (SH4 RN / RZ)
//   - s1_t: normalized-quotient register between normalize and round/pack
package fpu_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FBF_FFFF;

    // Internal signed exponent width; wide enough that exp_in-1 and the
    // rounding carry can never wrap for any supported input width.
    localparam int unsigned S1_EXP_W = 16;

    typedef enum logic {
        RM_RN = 1'b0,
        RM_RZ = 1'b1
    } rm_e;

    typedef struct packed {
        logic                       sign;
        logic                       sp_nan;
        logic                       sp_inf;
        logic                       sp_zero;
        rm_e                        rm;
        logic signed [S1_EXP_W-1:0] exp;
        logic [MAN_W:0]             mant;
        logic                       guard;
        logic                       sticky;
    } s1_t;

endpackage

// File: rtl/fp_round_rne_rz.sv
// fp_round_rne_rz: combinational mantissa rounding (RN nearest-even / RZ).
// Ports:
//   mant_in  - MW-bit normalized mantissa (leading 1 at MSB)
//   guard    - first bit below the mantissa LSB
//   sticky   - OR of all bits below guard
//   rm       - rounding mode
//   mant_out - rounded mantissa; renormalized to 1.000.. on carry-out
//   carry    - rounding overflowed the mantissa (exponent must increment)
//   inexact  - any discarded bit was nonzero
module fp_round_rne_rz
    import fpu_pkg::*;
#(
    parameter int unsigned MW = 24
) (
    input  logic [MW-1:0] mant_in,
    input  logic          guard,
    input  logic          sticky,
    input  rm_e           rm,
    output logic [MW-1:0] mant_out,
    output logic          carry,
    output logic          inexact
);

    logic        inc;
    logic [MW:0] sum;

    always_comb begin
        inc      = (rm == RM_RN) & guard & (sticky | mant_in[0]);
        sum      = {1'b0, mant_in} + (MW+1)'(inc);
        carry    = sum[MW];
        mant_out = carry ? {1'b1, {(MW-1){1'b0}}} : sum[MW-1:0];
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fdiv_round_pack.sv
// fdiv_round_pack: divide post-processing. Normalizes the SRT quotient,
// rounds (RN/RZ), applies overflow / flush-to-zero underflow and special
// cases, and packs an IEEE-754 single. Two stages, one op per cycle.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   q_valid             - quotient + tags valid (pulse)
//   quotient            - QW-bit quotient, Q[QW-1] integer bit
//   rem_nz              - remainder nonzero (sticky)
//   sign, exp_in        - result sign, signed biased exponent
//   rm                  - 0 = RN, 1 = RZ
//   sp_nan/sp_inf/sp_zero - special-case tags (priority in that order)
//   res_valid           - result valid pulse, 2 cycles after q_valid
//   result, flg_*       - packed single and flags, held between results
module fdiv_round_pack
    import fpu_pkg::*;
#(
    parameter int unsigned QW   = 27,
    parameter int unsigned EW   = 10,
    parameter logic [31:0] QNAN = 32'h7FBF_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          q_valid,
    input  logic [QW-1:0] quotient,
    input  logic          rem_nz,
    input  logic          sign,
    input  logic [EW-1:0] exp_in,
    input  logic          rm,
    input  logic          sp_nan,
    input  logic          sp_inf,
    input  logic          sp_zero,
    output logic          res_valid,
    output logic [31:0]   result,
    output logic          flg_ovf,
    output logic          flg_unf,
    output logic          flg_inx
);

    localparam logic signed [S1_EXP_W-1:0] EXP_ONE = S1_EXP_W'(1);
    localparam logic signed [S1_EXP_W-1:0] EXP_TOP = S1_EXP_W'(EXP_MAX);

    s1_t         s1_d, s1_q;
    logic        s1_valid_d, s1_valid_q;
    logic        res_valid_d, res_valid_q;
    logic [31:0] result_d, result_q;
    logic        ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q;

    logic signed [S1_EXP_W-1:0] exp_ext;
    logic signed [S1_EXP_W-1:0] exp_fin;
    logic [MAN_W:0]             mant_r;
    logic                       rnd_carry;
    logic                       rnd_inx;

    // Stage 1: normalize into [1,2)
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = q_valid;
        exp_ext    = S1_EXP_W'(signed'(exp_in));
        if (q_valid) begin
            s1_d.sign    = sign;
            s1_d.sp_nan  = sp_nan;
            s1_d.sp_inf  = sp_inf;
            s1_d.sp_zero = sp_zero;
            s1_d.rm      = rm_e'(rm);
            if (quotient[QW-1]) begin
                s1_d.mant   = quotient[QW-1:QW-24];
                s1_d.guard  = quotient[QW-25];
                s1_d.sticky = (|quotient[QW-26:0]) | rem_nz;
                s1_d.exp    = exp_ext;
            end else begin
                s1_d.mant   = quotient[QW-2:QW-25];
                s1_d.guard  = quotient[QW-26];
                s1_d.sticky = (|quotient[QW-27:0]) | rem_nz;
                s1_d.exp    = exp_ext - EXP_ONE;
            end
        end
    end

    fp_round_rne_rz #(
        .MW (MAN_W + 1)
    ) u_round (
        .mant_in  (s1_q.mant),
        .guard    (s1_q.guard),
        .sticky   (s1_q.sticky),
        .rm       (s1_q.rm),
        .mant_out (mant_r),
        .carry    (rnd_carry),
        .inexact  (rnd_inx)
    );

    // Stage 2: round, range-check, pack
    always_comb begin
        res_valid_d = s1_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        exp_fin     = rnd_carry ? s1_q.exp + EXP_ONE : s1_q.exp;
        if (s1_valid_q) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inx_d = 1'b0;
            if (s1_q.sp_nan) begin
                result_d = QNAN;
            end else if (s1_q.sp_inf) begin
                result_d = {s1_q.sign, 8'hFF, 23'h0};
            end else if (s1_q.sp_zero) begin
                result_d = {s1_q.sign, 31'h0};
            end else if (exp_fin >= EXP_TOP) begin
                ovf_d    = 1'b1;
                inx_d    = 1'b1;
                result_d = (s1_q.rm == RM_RN) ? {s1_q.sign, 8'hFF, 23'h0}
                                              : {s1_q.sign, 8'hFE, 23'h7FFFFF};
            end else if (exp_fin <= 0) begin
                unf_d    = 1'b1;
                inx_d    = 1'b1;
                result_d = {s1_q.sign, 31'h0};
            end else if (!mant_r[MAN_W]) begin
                // Only reachable from an illegal 00.xx quotient; emit zero.
                inx_d    = rnd_inx;
                result_d = {s1_q.sign, 31'h0};
            end else begin
                inx_d    = rnd_inx;
                result_d = {s1_q.sign, exp_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign flg_ovf   = ovf_q;
    assign flg_unf   = unf_q;
    assign flg_inx   = inx_q;

endmodule
